// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared states, HD44780 command bytes and line geometry for lcd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP   = 3'd0,
        INIT    = 3'd1,
        IDLE    = 3'd2,
        SETADDR = 3'd3,
        WRCHAR  = 3'd4,
        FINISH  = 3'd5
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_PULSE = 2'd1,
        PH_WAIT  = 2'd2
    } xfer_phase_t;

    localparam logic [7:0] c_cmd_func_set = 8'h38;
    localparam logic [7:0] c_cmd_disp_on  = 8'h0C;
    localparam logic [7:0] c_cmd_entry    = 8'h06;
    localparam logic [7:0] c_cmd_clear    = 8'h01;
    localparam logic [7:0] c_cmd_line0    = 8'h80;
    localparam logic [7:0] c_cmd_line1    = 8'hC0;

    localparam int c_line_len  = 16;
    localparam int c_num_chars = 2 * c_line_len;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return c_cmd_func_set;
            2'd1:    return c_cmd_disp_on;
            2'd2:    return c_cmd_entry;
            default: return c_cmd_clear;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_xfer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_xfer
// Brief    : One HD44780 write: setup cycle, enable pulse, post-pulse wait.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_xfer
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] byte_val,
    input  logic       long_wait,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       active,
    output logic       xfer_done
);
    localparam int c_wait_max = (CLEAR_WAIT_CYC > CMD_WAIT_CYC) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
    localparam int c_max_cyc  = (c_wait_max > E_PULSE_CYC) ? c_wait_max : E_PULSE_CYC;
    localparam int c_cnt_w    = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_cnt_w-1:0] c_e_last   = c_cnt_w'(E_PULSE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last = c_cnt_w'(CMD_WAIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_clr_last = c_cnt_w'(CLEAR_WAIT_CYC - 1);

    xfer_phase_t        r_phase, w_phase_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_rs, r_long;
    logic [7:0]         r_data;
    logic               w_setup;
    logic [c_cnt_w-1:0] w_wait_last;

    // The go cycle is the setup cycle: bus values pass straight through, then hold.
    assign w_setup     = (r_phase == PH_IDLE) && go;
    assign w_wait_last = r_long ? c_clr_last : c_cmd_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_long  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_setup) begin
                r_rs   <= rs;
                r_data <= byte_val;
                r_long <= long_wait;
            end
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        xfer_done   = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (go) begin
                    w_phase_nxt = PH_PULSE;
                    w_cnt_nxt   = '0;
                end
            end
            PH_PULSE: begin
                if (r_cnt == c_e_last) begin
                    w_phase_nxt = PH_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PH_WAIT: begin
                if (r_cnt == w_wait_last) begin
                    w_phase_nxt = PH_IDLE;
                    w_cnt_nxt   = '0;
                    xfer_done   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_phase_nxt = PH_IDLE;
        endcase
    end

    assign lcd_e    = (r_phase == PH_PULSE);
    assign lcd_rs   = w_setup ? rs : r_rs;
    assign lcd_data = w_setup ? byte_val : r_data;
    assign active   = (r_phase != PH_IDLE);

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl
// Brief    : HD44780 8-bit controller: power-up, init, and 2x16 screen refresh.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done
);
    localparam int c_pwr_w = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;
    localparam logic [c_pwr_w-1:0] c_pwr_last  = c_pwr_w'(POWERUP_CYC - 1);
    localparam logic [4:0]         c_line_end  = 5'(c_line_len - 1);
    localparam logic [4:0]         c_last_char = 5'(c_num_chars - 1);

    lcd_state_t         r_state, w_state_nxt;
    logic [c_pwr_w-1:0] r_pwr_cnt, w_pwr_cnt_nxt;
    logic [1:0]         r_init_idx, w_init_idx_nxt;
    logic               r_line, w_line_nxt;
    logic [4:0]         r_char, w_char_nxt;
    logic               w_go, w_rs, w_long, w_active, w_xfer_done;
    logic [7:0]         w_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= PWRUP;
            r_pwr_cnt  <= '0;
            r_init_idx <= 2'd0;
            r_line     <= 1'b0;
            r_char     <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pwr_cnt  <= w_pwr_cnt_nxt;
            r_init_idx <= w_init_idx_nxt;
            r_line     <= w_line_nxt;
            r_char     <= w_char_nxt;
        end
    end

    // Sending states raise go whenever the transfer engine is free; they advance on xfer_done.
    always_comb begin
        w_state_nxt    = r_state;
        w_pwr_cnt_nxt  = r_pwr_cnt;
        w_init_idx_nxt = r_init_idx;
        w_line_nxt     = r_line;
        w_char_nxt     = r_char;
        w_go           = 1'b0;
        w_rs           = 1'b0;
        w_byte         = 8'h00;
        w_long         = 1'b0;
        case (r_state)
            PWRUP: begin
                if (r_pwr_cnt == c_pwr_last) begin
                    w_state_nxt   = INIT;
                    w_pwr_cnt_nxt = '0;
                end else begin
                    w_pwr_cnt_nxt = r_pwr_cnt + 1'b1;
                end
            end
            INIT: begin
                w_go   = !w_active;
                w_byte = init_cmd(r_init_idx);
                w_long = (r_init_idx == 2'd3);
                if (w_xfer_done) begin
                    if (r_init_idx == 2'd3) begin
                        w_state_nxt    = SETADDR;
                        w_init_idx_nxt = 2'd0;
                        w_line_nxt     = 1'b0;
                        w_char_nxt     = 5'd0;
                    end else begin
                        w_init_idx_nxt = r_init_idx + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (start) begin
                    w_state_nxt = SETADDR;
                    w_line_nxt  = 1'b0;
                    w_char_nxt  = 5'd0;
                end
            end
            SETADDR: begin
                w_go   = !w_active;
                w_byte = r_line ? c_cmd_line1 : c_cmd_line0;
                if (w_xfer_done) begin
                    w_state_nxt = WRCHAR;
                end
            end
            WRCHAR: begin
                w_go   = !w_active;
                w_rs   = 1'b1;
                w_byte = char_data;
                if (w_xfer_done) begin
                    // Index stops at the last character rather than wrapping to 0.
                    if (r_char == c_last_char) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_char_nxt = r_char + 5'd1;
                        if (r_char == c_line_end) begin
                            w_state_nxt = SETADDR;
                            w_line_nxt  = 1'b1;
                        end
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = PWRUP;
            end
        endcase
    end

    lcd_xfer #(
        .E_PULSE_CYC   (E_PULSE_CYC),
        .CMD_WAIT_CYC  (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
    ) u_xfer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (w_go),
        .rs       (w_rs),
        .byte_val (w_byte),
        .long_wait(w_long),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .active   (w_active),
        .xfer_done(w_xfer_done)
    );

    assign char_addr = r_char;
    assign lcd_rw    = 1'b0;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FINISH);

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter POWERUP_CYC, default 750000, meaning idle cycles after reset before the first command (15 ms at 50 MHz).
REQ-002 SHALL have parameter E_PULSE_CYC, default 25, meaning cycles lcd_e is held high per transfer.
REQ-003 SHALL have parameter CMD_WAIT_CYC, default 2500, meaning post-pulse wait cycles for ordinary commands and data bytes.
REQ-004 SHALL have parameter CLEAR_WAIT_CYC, default 100000, meaning post-pulse wait cycles after the clear command 0x01.
REQ-005 SHALL have port clk, input, 1, system clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle refresh request.
REQ-008 SHALL have port char_addr, output, 5, character index presented to the character ROM.
REQ-009 SHALL have port char_data, input, 8, ASCII byte returned combinationally for char_addr.
REQ-010 SHALL have ports lcd_rs, lcd_rw and lcd_e, output, 1 each, HD44780 control lines.
REQ-011 SHALL have port lcd_data, output, 8, HD44780 data bus.
REQ-012 SHALL have port busy, output, 1, high whenever a sequence is in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at the end of each refresh.

Function
REQ-014 SHALL implement states PWRUP, INIT, IDLE, SETADDR, WRCHAR and FINISH.
REQ-015 PWRUP SHALL count POWERUP_CYC cycles and then enter INIT.
REQ-016 INIT SHALL issue commands 0x38, 0x0C, 0x06, 0x01 in that order (rs=0) and then enter SETADDR with line 0, without waiting for start.
REQ-017 Each transfer SHALL be: 1 setup cycle (e=0, rs/data valid), then E_PULSE_CYC cycles with e=1, then the wait count with e=0 and rs/data held.
REQ-018 The wait count SHALL be CLEAR_WAIT_CYC for 0x01 and CMD_WAIT_CYC for every other byte.
REQ-019 SETADDR SHALL send 0x80 for line 0 and 0xC0 for line 1 (rs=0), then enter WRCHAR.
REQ-020 WRCHAR SHALL send char_data with rs=1 for char_addr = line*16 to line*16+15 in ascending order.
REQ-021 char_addr SHALL be stable from the setup cycle to the end of the wait count.
REQ-022 After char 15, WRCHAR SHALL go to SETADDR for line 1; after char 31, it SHALL go to FINISH.
REQ-023 FINISH SHALL pulse done for exactly 1 cycle and enter IDLE.
REQ-024 In IDLE, start=1 SHALL begin a refresh at SETADDR with line 0 on the next cycle.
REQ-025 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 lcd_rw SHALL be constant 0 (write-only, no busy-flag polling).
REQ-027 busy SHALL be 0 only in IDLE.
REQ-028 The 5-bit char index SHALL NOT wrap past 31 within one refresh.
REQ-029 Total refresh length SHALL equal 34 transfers.

Reset
REQ-030 On rst_n=0, asynchronously: state=PWRUP, counters=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, char_addr=0, done=0, busy=1.
REQ-031 Reset mid-transfer SHALL drop lcd_e immediately and restart the full power-up and init sequence after release.

Structure
REQ-032 Package lcd_pkg SHALL hold the state enum, the command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) and the line-length constant 16.
REQ-033 Sub-module lcd_xfer SHALL implement one transfer (inputs go, rs, byte, long_wait; output xfer_done pulse), instanced once.
REQ-034 The character ROM SHALL remain external and connect via char_addr/char_data.

Verification (POWERUP_CYC=10, E_PULSE_CYC=3, CMD_WAIT_CYC=5, CLEAR_WAIT_CYC=20, ROM model with the 32-char string)
REQ-035 Release reset -> lcd_e stays 0 for 10 cycles; then 4 e-pulses with data 38,0C,06,01 and rs=0; after 0x01, the next setup occurs 20 cycles after e falls.
REQ-036 Auto refresh after init -> e-falling-edge capture yields 0x80, 16 ROM bytes (rs=1), 0xC0, 16 ROM bytes; done pulses once, for 1 cycle; busy falls with done.
REQ-037 Transfer timing -> each e-high lasts exactly 3 cycles; lcd_data/lcd_rs/char_addr do not change while e=1 or during the 5-cycle wait.
REQ-038 start pulse during busy, then start in IDLE -> exactly one additional refresh (34 transfers), one done pulse.
REQ-039 Assert rst_n=0 while e=1 during char 7 -> lcd_e=0 in the same cycle; after release, the full sequence repeats from 0x38.
REQ-040 start held high for 3 cycles in IDLE -> a single refresh is started.
